// File: rtl/hd44780_nibble_if.sv
// HD44780 4-bit bus engine: takes bytes on a valid/ready handshake and emits them as
// one or two E-strobed nibbles (high first) to one of NUM_E displays on a shared bus.
module hd44780_nibble_if #(
  parameter int unsigned NUM_E         = 1,
  parameter int unsigned E_SETUP_CYC   = 2,
  parameter int unsigned E_HIGH_CYC    = 4,
  parameter int unsigned E_LOW_CYC     = 4,
  parameter int unsigned EXEC_CYC      = 40,
  parameter int unsigned EXEC_LONG_CYC = 1600,
  parameter int unsigned SEL_W         = (NUM_E > 1) ? $clog2(NUM_E) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rs,
  input  logic [7:0]       in_data,
  input  logic             in_nibble_only,
  input  logic [SEL_W-1:0] in_sel,
  output logic             rs,
  output logic [NUM_E-1:0] e,
  output logic [3:0]       d,
  output logic             busy
);

  // A zero-cycle phase would make no sense on the pads, so it is stretched to one.
  localparam int unsigned SETUP_N = (E_SETUP_CYC   == 0) ? 1 : E_SETUP_CYC;
  localparam int unsigned HIGH_N  = (E_HIGH_CYC    == 0) ? 1 : E_HIGH_CYC;
  localparam int unsigned LOW_N   = (E_LOW_CYC     == 0) ? 1 : E_LOW_CYC;
  localparam int unsigned EXEC_N  = (EXEC_CYC      == 0) ? 1 : EXEC_CYC;
  localparam int unsigned LONG_N  = (EXEC_LONG_CYC == 0) ? 1 : EXEC_LONG_CYC;
  localparam int unsigned MAX_A   = (SETUP_N > HIGH_N) ? SETUP_N : HIGH_N;
  localparam int unsigned MAX_B   = (LOW_N > EXEC_N) ? LOW_N : EXEC_N;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_N   = (MAX_C > LONG_N) ? MAX_C : LONG_N;
  localparam int unsigned CNT_W   = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SET_H, ST_PUL_H, ST_HLD_H, ST_SET_L, ST_PUL_L, ST_HLD_L, ST_EXEC
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rs_lat_reg, nib_lat_reg, long_lat_reg;
  logic [7:0]       data_lat_reg;
  logic [SEL_W-1:0] sel_lat_reg;
  logic             rs_reg, rs_next;
  logic [3:0]       d_reg, d_next;
  logic [NUM_E-1:0] e_reg, e_next;
  logic             ready_reg, busy_reg;
  logic             take, long_in, long_sel;
  logic [NUM_E-1:0] sel_onehot;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign take     = (state_reg == ST_IDLE) && in_valid;
  assign long_in  = !in_rs && !in_nibble_only && (in_data[7:2] == 6'd0) && (in_data != 8'd0);
  assign long_sel = take ? long_in : long_lat_reg;

  // An out-of-range select matches no bit, so the write is silently dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_E; gi++) begin : g_sel
      assign sel_onehot[gi] = (sel_lat_reg == SEL_W'(gi));
    end
  endgenerate

  function automatic logic [CNT_W-1:0] residency(input state_t st, input logic lng);
    case (st)
      ST_SET_H, ST_SET_L: residency = CNT_W'(SETUP_N);
      ST_PUL_H, ST_PUL_L: residency = CNT_W'(HIGH_N);
      ST_HLD_H, ST_HLD_L: residency = CNT_W'(LOW_N);
      ST_EXEC:            residency = lng ? CNT_W'(LONG_N) : CNT_W'(EXEC_N);
      default:            residency = CNT_W'(1);
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rs_next    = rs_reg;
    d_next     = d_reg;
    e_next     = '0;

    if (state_reg == ST_IDLE) begin
      if (in_valid) state_next = ST_SET_H;
    end else if (cnt_reg > CNT_W'(1)) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end else begin
      case (state_reg)
        ST_SET_H: state_next = ST_PUL_H;
        ST_PUL_H: state_next = ST_HLD_H;
        ST_HLD_H: state_next = nib_lat_reg ? ST_EXEC : ST_SET_L;
        ST_SET_L: state_next = ST_PUL_L;
        ST_PUL_L: state_next = ST_HLD_L;
        ST_HLD_L: state_next = ST_EXEC;
        default:  state_next = ST_IDLE;
      endcase
    end
    if (state_next != state_reg) cnt_next = residency(state_next, long_sel);

    case (state_next)
      ST_SET_H: begin
        rs_next = take ? in_rs : rs_lat_reg;
        d_next  = take ? in_data[7:4] : data_lat_reg[7:4];
      end
      ST_SET_L:           d_next = data_lat_reg[3:0];
      ST_PUL_H, ST_PUL_L: e_next = sel_onehot;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      rs_lat_reg   <= 1'b0;
      nib_lat_reg  <= 1'b0;
      long_lat_reg <= 1'b0;
      data_lat_reg <= '0;
      sel_lat_reg  <= '0;
      rs_reg       <= 1'b0;
      d_reg        <= '0;
      e_reg        <= '0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (take) begin
        rs_lat_reg   <= in_rs;
        nib_lat_reg  <= in_nibble_only;
        long_lat_reg <= long_in;
        data_lat_reg <= in_data;
        sel_lat_reg  <= in_sel;
      end
      rs_reg    <= rs_next;
      d_reg     <= d_next;
      e_reg     <= e_next;
      ready_reg <= (state_next == ST_IDLE);
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  assign in_ready = ready_reg;
  assign busy     = busy_reg;
  assign rs       = rs_reg;
  assign d        = d_reg;
  assign e        = e_reg;

endmodule

// File: tb/tb_hd44780_nibble_if.sv
// Bench for hd44780_nibble_if (NUM_E=3): directed literal checks plus randomized bytes
// compared every cycle against a timeline model derived from the phase lengths.
module tb_hd44780_nibble_if;
  localparam int S = 2, H = 4, L = 4, X = 40, XL = 1600, NE = 3;
  localparam int SEG = S + H + L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_nibble_only = 1'b0;
  logic [1:0] in_sel = 2'd0;
  logic       rs;
  logic [2:0] e;
  logic [3:0] d;
  logic       busy;

  hd44780_nibble_if #(.NUM_E(NE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
    .in_data(in_data), .in_nibble_only(in_nibble_only), .in_sel(in_sel),
    .rs(rs), .e(e), .d(d), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int nprint = 0;
  int hs_cyc = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int busy_len(input logic r, input logic [7:0] dat, input logic nb);
    return (nb ? SEG : 2 * SEG) + ((!nb && !r && dat >= 8'd1 && dat <= 8'd3) ? XL : X);
  endfunction

  // Expected {ready,busy,rs,e,d} k edges after the handshake edge of a byte still in flight.
  function automatic logic [9:0] txn_out(input int k, input logic r, input logic [7:0] dat,
                                         input logic nb, input logic [1:0] sl);
    int p, span, q;
    logic [3:0] dd;
    logic [2:0] ee;
    p = k - 1;
    span = nb ? SEG : 2 * SEG;
    ee = '0;
    if (p < span) begin
      q = p % SEG;
      dd = (p < SEG) ? dat[7:4] : dat[3:0];
      if (q >= S && q < S + H && int'(sl) < NE) ee = 3'(1 << sl);
    end else begin
      dd = nb ? dat[7:4] : dat[3:0];
    end
    return {1'b0, 1'b1, r, ee, dd};
  endfunction

  logic       m_act = 1'b0, m_ok = 1'b0, rst_pend = 1'b0;
  logic       m_rs = 1'b0, m_nib = 1'b0, m_last_rs = 1'b0;
  logic [7:0] m_data = 8'd0;
  logic [1:0] m_sel = 2'd0;
  logic [3:0] m_last_d = 4'd0;
  int         m_k = 0, m_busy = 0;
  logic [9:0] exp_v, act_v;

  always @(negedge clk) begin
    if (rst_pend) begin
      m_act = 1'b0; m_last_rs = 1'b0; m_last_d = 4'd0; m_ok = 1'b1; rst_pend = 1'b0;
    end
    if (m_act) begin
      m_k++;
      if (m_k > m_busy) begin
        m_act = 1'b0;
        m_last_rs = m_rs;
        m_last_d = m_nib ? m_data[7:4] : m_data[3:0];
      end
    end
    exp_v = m_act ? txn_out(m_k, m_rs, m_data, m_nib, m_sel)
                  : {1'b1, 1'b0, m_last_rs, 3'b000, m_last_d};
    if (m_ok) begin
      act_v = {in_ready, busy, rs, e, d};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle_out cyc=%0d rdy/busy/rs/e/d actual=%b required=%b", cyc, act_v, exp_v);
        end
      end
    end
    if (rst) rst_pend = 1'b1;
    else if (m_ok && exp_v[9] && in_valid) begin
      m_act = 1'b1; m_k = 0;
      m_rs = in_rs; m_data = in_data; m_nib = in_nibble_only; m_sel = in_sel;
      m_busy = busy_len(in_rs, in_data, in_nibble_only);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge, valid still high.
  task automatic start(input logic r, input logic [7:0] dat, input logic nb, input logic [1:0] sl);
    int guard;
    guard = 0;
    in_rs = r; in_data = dat; in_nibble_only = nb; in_sel = sl; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL handshake_wait actual=0 required=1");
    end
    @(posedge clk);
    hs_cyc = cyc;
    #1;
    $display("txn rs=%0d data=%02h nib=%0d sel=%0d accepted cyc=%0d", r, dat, nb, sl, hs_cyc);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_rs = 1'($urandom); in_data = 8'($urandom);
    in_nibble_only = 1'($urandom); in_sel = 2'($urandom);
  endtask

  task automatic measure(output int busy_n, output int npul, output logic [2:0] e_or,
                         output logic [3:0] n1, output logic [3:0] n2);
    logic [2:0] e_prev;
    int guard;
    e_prev = '0; guard = 0;
    busy_n = 0; npul = 0; e_or = '0; n1 = '0; n2 = '0;
    @(negedge clk);
    while (!in_ready && guard < 4000) begin
      busy_n++;
      if (e != 3'b000 && e_prev == 3'b000) begin
        npul++;
        if (npul == 1) n1 = d; else n2 = d;
      end
      e_or |= e;
      e_prev = e;
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bn, np, c1, c2, c3;
    logic [2:0] eo;
    logic [3:0] n1, n2;
    logic r, nb;
    logic [7:0] dat;
    logic [1:0] sl;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", int'({in_ready, busy, rs, e, d}), int'(10'b1_0_0_000_0000));
    @(posedge clk);
    #1;

    start(1'b1, 8'h48, 1'b0, 2'd0); idle_in(); measure(bn, np, eo, n1, n2);
    chk("data48_busy", bn, 60); chk("data48_pulses", np, 2);
    chk("data48_hi", int'(n1), 4); chk("data48_lo", int'(n2), 8); chk("data48_e", int'(eo), 1);

    start(1'b0, 8'h01, 1'b0, 2'd0); idle_in(); measure(bn, np, eo, n1, n2);
    chk("clear_busy", bn, 1620); chk("clear_lo", int'(n2), 1);
    start(1'b0, 8'h80, 1'b0, 2'd0); idle_in(); measure(bn, np, eo, n1, n2);
    chk("cmd80_busy", bn, 60); chk("cmd80_hi", int'(n1), 8);

    start(1'b0, 8'h30, 1'b1, 2'd1); idle_in(); measure(bn, np, eo, n1, n2);
    chk("nib_busy", bn, 50); chk("nib_pulses", np, 1);
    chk("nib_hi", int'(n1), 3); chk("nib_e", int'(eo), 2);

    start(1'b1, 8'h41, 1'b0, 2'd2); idle_in(); measure(bn, np, eo, n1, n2);
    chk("sel2_e", int'(eo), 4); chk("sel2_pulses", np, 2);
    start(1'b1, 8'h41, 1'b0, 2'd3); idle_in(); measure(bn, np, eo, n1, n2);
    chk("sel3_e", int'(eo), 0); chk("sel3_busy", bn, 60);

    start(1'b1, 8'hA5, 1'b0, 2'd1); idle_in();
    repeat (14) @(negedge clk);
    chk("pul_l_e", int'(e), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_state", int'({in_ready, busy, rs, e, d}), int'(10'b1_0_0_000_0000));
    @(posedge clk); #1;
    start(1'b0, 8'h80, 1'b0, 2'd0); idle_in(); measure(bn, np, eo, n1, n2);
    chk("after_abort_busy", bn, 60); chk("after_abort_hi", int'(n1), 8);

    start(1'b1, 8'h11, 1'b0, 2'd0); c1 = hs_cyc;
    start(1'b1, 8'h22, 1'b0, 2'd1); c2 = hs_cyc;
    start(1'b1, 8'h33, 1'b0, 2'd2); c3 = hs_cyc;
    idle_in(); measure(bn, np, eo, n1, n2);
    chk("b2b_gap1", c2 - c1, 61); chk("b2b_gap2", c3 - c2, 61);

    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom); nb = ($urandom_range(0, 3) == 0);
      dat = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      sl = 2'($urandom);
      start(r, dat, nb, sl);
      if ($urandom_range(0, 2) != 0) begin
        idle_in();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    idle_in(); measure(bn, np, eo, n1, n2);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
